// File: rtl/jtag_tunnel_mux_n.sv
// jtag_tunnel_mux_n: N-channel JTAG tunnel clocked by TCK.
// A config USER chain selects the channel and mode. A tunnel USER chain carries
// bursts made of a header (IR/DR flag, scan length) followed by data. Each burst
// is expanded into full TMS/TDI sequences for the selected downstream TAP(s).
//
// state | meaning
// IDLE  | waiting for a burst; TMS held low so targets sit in Run-Test/Idle
// HDR   | collecting the scan-length field, LSB first
// PRE   | walking targets from RTI to Shift-DR or Shift-IR
// DATA  | forwarding payload bits; TMS high on the last bit (Exit1)
// POST  | Update then back to RTI
// DONE  | burst complete; waiting for the host to end the shift
// ABORT | host ended the shift early; five TMS=1 reach Test-Logic-Reset, then RTI
module jtag_tunnel_mux_n #(
  parameter int NUM_CHAN = 16,
  parameter int SEL_W    = $clog2(NUM_CHAN),
  parameter int LEN_W    = 7,
  parameter int CFG_W    = 8
) (
  input  logic                tck_i,
  input  logic                reset_i,
  input  logic                cfg_sel_i,
  input  logic                cfg_capture_i,
  input  logic                cfg_shift_i,
  input  logic                cfg_update_i,
  input  logic                cfg_tdi_i,
  output logic                cfg_tdo_o,
  input  logic                tun_sel_i,
  input  logic                tun_shift_i,
  input  logic                tun_tdi_i,
  output logic                tun_tdo_o,
  output logic [NUM_CHAN-1:0] ch_tck_en_o,
  output logic [NUM_CHAN-1:0] ch_tms_o,
  output logic [NUM_CHAN-1:0] ch_tdi_o,
  input  logic [NUM_CHAN-1:0] ch_tdo_i,
  input  logic [NUM_CHAN-1:0] ch_tdo_en_i,
  output logic [NUM_CHAN-1:0] ch_sel_o
);

  // The index field spans every bit below abort_sticky, so a value beyond the
  // channel count selects nothing instead of aliasing onto a real channel.
  localparam int IDX_W = CFG_W - 2;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_PRE, S_DATA, S_POST, S_DONE, S_ABORT
  } state_t;

  state_t             state_q;
  logic               tms_q;
  logic               tdi_q;
  logic               ir_q;
  logic [LEN_W-1:0]   len_q;
  logic [3:0]         step_q;

  logic [CFG_W-1:0]   shreg_q;
  logic [CFG_W-1:0]   new_q;
  logic               pend_q;
  logic [IDX_W-1:0]   idx_q;
  logic               bcast_q;
  logic               sticky_q;

  logic [CFG_W-1:0]   cfg_rd;
  logic [LEN_W-1:0]   len_nxt;
  logic               abort_hit;
  logic               apply;
  logic               pre_tms;
  logic               pre_last;
  logic               idx_hi_zero;
  logic [NUM_CHAN-1:0] active;

  assign cfg_rd    = {bcast_q, sticky_q, idx_q};
  assign cfg_tdo_o = shreg_q[0];
  assign len_nxt   = {tun_tdi_i, len_q[LEN_W-1:1]};
  assign apply     = pend_q && (state_q == S_IDLE);
  assign abort_hit = tun_sel_i && !tun_shift_i &&
                     ((state_q == S_HDR) || (state_q == S_PRE) ||
                      (state_q == S_DATA) || (state_q == S_POST));

  // DR preamble is 1,0,0; IR preamble is 1,1,0,0
  assign pre_tms  = ir_q ? (step_q < 4'd2) : (step_q == 4'd0);
  assign pre_last = ir_q ? (step_q == 4'd3) : (step_q == 4'd2);

  // Config shift chain; a completed update is held pending until the tunnel is idle
  always_ff @(posedge tck_i or posedge reset_i) begin
    if (reset_i) begin
      shreg_q <= '0;
      new_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      if (apply) pend_q <= 1'b0;
      if (cfg_sel_i) begin
        if (cfg_capture_i)    shreg_q <= cfg_rd;
        else if (cfg_shift_i) shreg_q <= {cfg_tdi_i, shreg_q[CFG_W-1:1]};
        if (cfg_update_i) begin
          pend_q <= 1'b1;
          new_q  <= shreg_q;
        end
      end
    end
  end

  // Live configuration: pending value applied in IDLE; abort sets the sticky flag
  always_ff @(posedge tck_i or posedge reset_i) begin
    if (reset_i) begin
      idx_q    <= '0;
      bcast_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      if (apply) begin
        idx_q   <= new_q[IDX_W-1:0];
        bcast_q <= new_q[CFG_W-1];
        if (new_q[CFG_W-2]) sticky_q <= 1'b0;
      end
      if (abort_hit) sticky_q <= 1'b1;
    end
  end

  // Tunnel FSM; advances only while the tunnel instruction is selected
  always_ff @(posedge tck_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b1;
      ir_q    <= 1'b0;
      len_q   <= '0;
      step_q  <= '0;
    end else if (tun_sel_i) begin
      tdi_q <= 1'b1;
      if (abort_hit) begin
        tms_q   <= 1'b1;
        step_q  <= '0;
        state_q <= S_ABORT;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            tms_q <= 1'b0;
            if (tun_shift_i) begin
              ir_q    <= ~tun_tdi_i;
              len_q   <= '0;
              step_q  <= '0;
              state_q <= S_HDR;
            end
          end
          S_HDR: begin
            tms_q  <= 1'b0;
            len_q  <= len_nxt;
            step_q <= step_q + 4'd1;
            if (step_q == 4'(LEN_W - 1)) begin
              step_q  <= '0;
              state_q <= (len_nxt == '0) ? S_DONE : S_PRE;
            end
          end
          S_PRE: begin
            tms_q  <= pre_tms;
            step_q <= step_q + 4'd1;
            if (pre_last) begin
              step_q  <= '0;
              state_q <= S_DATA;
            end
          end
          S_DATA: begin
            tdi_q <= tun_tdi_i;
            tms_q <= (len_q <= LEN_W'(1));
            if (len_q != '0) len_q <= len_q - LEN_W'(1);
            if (len_q <= LEN_W'(1)) state_q <= S_POST;
          end
          S_POST: begin
            tms_q  <= (step_q == 4'd0);
            step_q <= step_q + 4'd1;
            if (step_q == 4'd1) begin
              step_q  <= '0;
              state_q <= S_DONE;
            end
          end
          S_DONE: begin
            tms_q <= 1'b0;
            if (!tun_shift_i) state_q <= S_IDLE;
          end
          S_ABORT: begin
            step_q <= step_q + 4'd1;
            if (step_q == 4'd4) begin
              tms_q   <= 1'b0;
              step_q  <= '0;
              state_q <= S_IDLE;
            end else begin
              tms_q <= 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign idx_hi_zero = ((idx_q >> SEL_W) == '0);

  for (genvar i = 0; i < NUM_CHAN; i++) begin : g_act
    assign active[i] = bcast_q | (idx_hi_zero & (idx_q[SEL_W-1:0] == SEL_W'(i)));
  end

  assign ch_sel_o    = active;
  assign ch_tck_en_o = active & {NUM_CHAN{tun_sel_i}};
  assign ch_tms_o    = ~active | {NUM_CHAN{tms_q}};
  assign ch_tdi_o    = ~active | {NUM_CHAN{tdi_q}};

  // Return path always follows the indexed channel, also in broadcast mode
  always_comb begin
    tun_tdo_o = 1'b1;
    for (int i = 0; i < NUM_CHAN; i++) begin
      if (idx_hi_zero && (idx_q[SEL_W-1:0] == SEL_W'(i)) && ch_tdo_en_i[i])
        tun_tdo_o = ch_tdo_i[i];
    end
  end

endmodule

// File: tb/tb_jtag_tunnel_mux_n.sv
// Directed bench for jtag_tunnel_mux_n (NUM_CHAN=16, LEN_W=7, CFG_W=8).
module tb_jtag_tunnel_mux_n;

  logic        tck_i, reset_i;
  logic        cfg_sel_i, cfg_capture_i, cfg_shift_i, cfg_update_i, cfg_tdi_i;
  logic        cfg_tdo_o;
  logic        tun_sel_i, tun_shift_i, tun_tdi_i;
  logic        tun_tdo_o;
  logic [15:0] ch_tck_en_o, ch_tms_o, ch_tdi_o, ch_sel_o;
  logic [15:0] ch_tdo_i, ch_tdo_en_i;

  int          total = 0;
  int          bad   = 0;
  logic [63:0] tms_rec, tdi_rec;
  int          nrec;
  logic [7:0]  rd;
  logic [5:0]  abort_rec;

  jtag_tunnel_mux_n #(.NUM_CHAN(16), .LEN_W(7), .CFG_W(8)) dut (
    .tck_i(tck_i), .reset_i(reset_i),
    .cfg_sel_i(cfg_sel_i), .cfg_capture_i(cfg_capture_i), .cfg_shift_i(cfg_shift_i),
    .cfg_update_i(cfg_update_i), .cfg_tdi_i(cfg_tdi_i), .cfg_tdo_o(cfg_tdo_o),
    .tun_sel_i(tun_sel_i), .tun_shift_i(tun_shift_i), .tun_tdi_i(tun_tdi_i),
    .tun_tdo_o(tun_tdo_o),
    .ch_tck_en_o(ch_tck_en_o), .ch_tms_o(ch_tms_o), .ch_tdi_o(ch_tdi_o),
    .ch_tdo_i(ch_tdo_i), .ch_tdo_en_i(ch_tdo_en_i), .ch_sel_o(ch_sel_o)
  );

  initial tck_i = 1'b0;
  always #5 tck_i = ~tck_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge tck_i);
    #1;
  endtask

  task automatic cfg_write(input logic [7:0] val, output logic [7:0] rdv);
    cfg_sel_i = 1'b1; cfg_capture_i = 1'b1;
    tick();
    cfg_capture_i = 1'b0; cfg_shift_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      rdv[k]    = cfg_tdo_o;
      cfg_tdi_i = val[k];
      tick();
    end
    cfg_shift_i = 1'b0; cfg_update_i = 1'b1;
    tick();
    cfg_update_i = 1'b0; cfg_sel_i = 1'b0;
  endtask

  task automatic sbit(input logic b);
    tun_tdi_i = b;
    tick();
    tms_rec[nrec] = ch_tms_o[3];
    tdi_rec[nrec] = ch_tdi_o[3];
    nrec++;
  endtask

  task automatic burst(input logic ir, input int len, input logic [15:0] data);
    logic [6:0] lv;
    lv = 7'(len);
    nrec = 0; tms_rec = '0; tdi_rec = '0;
    tun_shift_i = 1'b1;
    sbit(~ir);
    for (int i = 0; i < 7; i++) sbit(lv[i]);
    for (int i = 0; i < (ir ? 4 : 3); i++) sbit(1'b0);
    for (int i = 0; i < len; i++) sbit(data[i]);
    sbit(1'b0); sbit(1'b0);
    sbit(1'b0);
    tun_shift_i = 1'b0;
    tick();
  endtask

  initial begin
    reset_i = 1'b1;
    cfg_sel_i = 0; cfg_capture_i = 0; cfg_shift_i = 0; cfg_update_i = 0; cfg_tdi_i = 0;
    tun_sel_i = 0; tun_shift_i = 0; tun_tdi_i = 0;
    ch_tdo_i = '0; ch_tdo_en_i = '0;
    #12;
    chk("rst_sel", ch_sel_o, 16'h0001);
    chk("rst_tck_en", ch_tck_en_o, 16'h0000);
    chk("rst_tms", ch_tms_o, 16'hFFFF);
    chk("rst_tdi", ch_tdi_o, 16'hFFFF);
    chk("rst_cfg_tdo", cfg_tdo_o, 1'b0);
    chk("rst_tun_tdo", tun_tdo_o, 1'b1);
    reset_i = 1'b0;
    tick();

    // select channel 3
    cfg_write(8'h03, rd);
    chk("rd_initial", rd, 8'h00);
    tun_sel_i = 1'b1;
    tick();
    chk("ch3_sel", ch_sel_o, 16'h0008);
    chk("ch3_tck_en", ch_tck_en_o, 16'h0008);
    chk("ch3_tms_idle", ch_tms_o, 16'hFFF7);
    chk("ch3_tdi_idle", ch_tdi_o, 16'hFFFF);
    tun_sel_i = 1'b0; #1;
    chk("ch3_tck_en_nosel", ch_tck_en_o, 16'h0000);
    tun_sel_i = 1'b1; #1;

    // return path
    ch_tdo_i = 16'h0000; ch_tdo_en_i = 16'h0000; #1;
    chk("tdo_noen", tun_tdo_o, 1'b1);
    ch_tdo_en_i = 16'h0008; #1;
    chk("tdo_en0", tun_tdo_o, 1'b0);
    ch_tdo_i = 16'h0008; #1;
    chk("tdo_en1", tun_tdo_o, 1'b1);
    ch_tdo_i = 16'hFFF7; ch_tdo_en_i = 16'hFFFF; #1;
    chk("tdo_others_ignored", tun_tdo_o, 1'b0);

    // DR burst, len 8, data A5
    burst(1'b0, 8, 16'h00A5);
    chk("dr_nbits", nrec, 22);
    chk("dr_tms", tms_rec, 64'h00000000000C0100);
    chk("dr_tdi", tdi_rec, 64'h00000000003D2FFF);
    chk("dr_data", tdi_rec[18:11], 8'hA5);

    // IR burst, len 5
    burst(1'b1, 5, 16'h0013);
    chk("ir_nbits", nrec, 20);
    chk("ir_tms", tms_rec, 64'h0000000000030300);

    // config change during DATA is deferred until idle
    fork
      burst(1'b0, 15, 16'h1234);
      begin
        repeat (12) tick();
        cfg_write(8'h05, rd);
      end
    join
    chk("defer_tms", tms_rec, 64'h0000000006000100);
    chk("defer_rd", rd, 8'h03);
    chk("defer_sel_held", ch_sel_o, 16'h0008);
    tick();
    chk("defer_sel_applied", ch_sel_o, 16'h0020);

    // abort at DATA bit 3
    cfg_write(8'h03, rd);
    chk("rd_ch5", rd, 8'h05);
    tick();
    chk("back_ch3", ch_sel_o, 16'h0008);
    nrec = 0; tms_rec = '0; tdi_rec = '0;
    tun_shift_i = 1'b1;
    sbit(1'b1);
    sbit(1'b0); sbit(1'b0); sbit(1'b0); sbit(1'b1); sbit(1'b0); sbit(1'b0); sbit(1'b0);
    sbit(1'b0); sbit(1'b0); sbit(1'b0);
    sbit(1'b1); sbit(1'b0); sbit(1'b1);
    tun_shift_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      abort_rec[i] = ch_tms_o[3];
    end
    chk("abort_tms", abort_rec, 6'b011111);
    tick();
    chk("abort_idle_tms", ch_tms_o[3], 1'b0);
    cfg_write(8'h03, rd);
    chk("sticky_set", rd, 8'h43);
    tick();
    cfg_write(8'h43, rd);
    chk("sticky_still", rd, 8'h43);
    tick();
    cfg_write(8'h80, rd);
    chk("sticky_cleared", rd, 8'h03);
    tick();

    // broadcast, index 0
    chk("bc_sel", ch_sel_o, 16'hFFFF);
    chk("bc_tck_en", ch_tck_en_o, 16'hFFFF);
    chk("bc_tms", ch_tms_o, 16'h0000);
    ch_tdo_i = 16'h0000; ch_tdo_en_i = 16'h0001; #1;
    chk("bc_tdo_ch0", tun_tdo_o, 1'b0);

    // out-of-range index
    cfg_write(8'h1F, rd);
    chk("rd_bc", rd, 8'h80);
    tick();
    ch_tdo_en_i = 16'hFFFF; #1;
    chk("oor_sel", ch_sel_o, 16'h0000);
    chk("oor_tck_en", ch_tck_en_o, 16'h0000);
    chk("oor_tms", ch_tms_o, 16'hFFFF);
    chk("oor_tdo", tun_tdo_o, 1'b1);

    // async reset in the middle of a burst
    tun_shift_i = 1'b1; tun_tdi_i = 1'b1;
    repeat (5) tick();
    #2 reset_i = 1'b1;
    #1;
    chk("arst_sel", ch_sel_o, 16'h0001);
    chk("arst_tms", ch_tms_o, 16'hFFFF);
    chk("arst_tdo", tun_tdo_o, 1'b0);
    chk("arst_cfg_tdo", cfg_tdo_o, 1'b0);
    tun_shift_i = 1'b0;
    #3 reset_i = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
